osd_mixer: RTL and testbench

OSD_MIXER -- requirements
Module: osd_mixer

---
 rtl/osd_mixer.sv | 204 ++++++++++++++++++++
 tb/tb_osd_mixer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/osd_mixer.sv
// osd_mixer: overlays a rectangular on-screen-display window onto a video stream.
// Window geometry and mode are shadowed at the start of each frame (vsync rise).
// Fetch coordinates go to an external OSD source of C_latency cycles. Video, timing
// and the window hit are delayed to line up with the returned OSD pixel.
module osd_mixer #(
    parameter int C_bits    = 8,
    parameter int C_xy_bits = 11,
    parameter int C_latency = 1
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   clk_pixel_ena,
    input  logic [C_bits-1:0]      i_r,
    input  logic [C_bits-1:0]      i_g,
    input  logic [C_bits-1:0]      i_b,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_blank,
    input  logic [C_xy_bits-1:0]   i_x0,
    input  logic [C_xy_bits-1:0]   i_y0,
    input  logic [C_xy_bits-1:0]   i_w,
    input  logic [C_xy_bits-1:0]   i_h,
    input  logic [1:0]             i_mode,
    input  logic [3*C_bits-1:0]    i_key,
    input  logic [C_bits-1:0]      i_osd_r,
    input  logic [C_bits-1:0]      i_osd_g,
    input  logic [C_bits-1:0]      i_osd_b,
    output logic [C_xy_bits-1:0]   o_osd_x,
    output logic [C_xy_bits-1:0]   o_osd_y,
    output logic                   o_osd_valid,
    output logic [C_bits-1:0]      o_r,
    output logic [C_bits-1:0]      o_g,
    output logic [C_bits-1:0]      o_b,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_blank
);

    // Delay-line word: {r, g, b, hsync, vsync, blank, hit, mode}
    localparam int DW    = 3 * C_bits + 6;
    localparam int DEPTH = C_latency + 1;
    localparam logic [C_xy_bits-1:0] XY_ONE = {{(C_xy_bits-1){1'b0}}, 1'b1};

    logic [C_xy_bits-1:0] px_r, py_r;
    logic                 vsync_d_r, blank_d_r;
    logic [C_xy_bits-1:0] x0_r, y0_r, w_r, h_r;
    logic [1:0]           mode_r;
    logic [C_xy_bits:0]   x_end_s, y_end_s;
    logic                 hit_s;
    logic [DW-1:0]        dly_r [DEPTH];
    logic [DW-1:0]        aligned_s;
    logic [C_bits-1:0]    a_r_s, a_g_s, a_b_s;
    logic                 a_hsync_s, a_vsync_s, a_blank_s, a_hit_s;
    logic [1:0]           a_mode_s;
    logic [C_bits:0]      sum_r_s, sum_g_s, sum_b_s;
    logic [C_bits-1:0]    mix_r_s, mix_g_s, mix_b_s;

    // Window hit test against shadow geometry; sums carry an extra bit so they never wrap
    always_comb begin
        x_end_s = {1'b0, x0_r} + {1'b0, w_r};
        y_end_s = {1'b0, y0_r} + {1'b0, h_r};
        hit_s   = ~i_blank
                  && ({1'b0, px_r} >= {1'b0, x0_r}) && ({1'b0, px_r} < x_end_s)
                  && ({1'b0, py_r} >= {1'b0, y0_r}) && ({1'b0, py_r} < y_end_s);
    end

    // Pixel/line counters and the vsync/blank edge detectors
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            px_r      <= '0;
            py_r      <= '0;
            vsync_d_r <= 1'b0;
            blank_d_r <= 1'b0;
        end else if (clk_pixel_ena) begin
            px_r      <= i_blank ? '0 : px_r + XY_ONE;
            if (i_vsync) begin
                py_r <= '0;
            end else if (i_blank && !blank_d_r) begin
                py_r <= py_r + XY_ONE;
            end
            vsync_d_r <= i_vsync;
            blank_d_r <= i_blank;
        end
    end

    // Shadow window geometry and mode, reloaded only at the start of a frame
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            x0_r   <= '0;
            y0_r   <= '0;
            w_r    <= '0;
            h_r    <= '0;
            mode_r <= 2'd0;
        end else if (clk_pixel_ena && i_vsync && !vsync_d_r) begin
            x0_r   <= i_x0;
            y0_r   <= i_y0;
            w_r    <= i_w;
            h_r    <= i_h;
            mode_r <= i_mode;
        end
    end

    // Fetch coordinates for the OSD source; held while outside the window
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            o_osd_valid <= 1'b0;
            o_osd_x     <= '0;
            o_osd_y     <= '0;
        end else if (clk_pixel_ena) begin
            o_osd_valid <= hit_s;
            if (hit_s) begin
                o_osd_x <= px_r - x0_r;
                o_osd_y <= py_r - y0_r;
            end
        end
    end

    // Delay line aligning video, timing, hit and mode with the returned OSD pixel
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dly_r[i] <= '0;
            end
        end else if (clk_pixel_ena) begin
            dly_r[0] <= {i_r, i_g, i_b, i_hsync, i_vsync, i_blank, hit_s, mode_r};
            for (int i = 1; i < DEPTH; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Unpack the aligned word and choose the mixed pixel
    always_comb begin
        aligned_s = dly_r[DEPTH-1];
        a_r_s     = aligned_s[DW-1 -: C_bits];
        a_g_s     = aligned_s[DW-1-C_bits -: C_bits];
        a_b_s     = aligned_s[DW-1-2*C_bits -: C_bits];
        a_hsync_s = aligned_s[5];
        a_vsync_s = aligned_s[4];
        a_blank_s = aligned_s[3];
        a_hit_s   = aligned_s[2];
        a_mode_s  = aligned_s[1:0];
        sum_r_s   = {1'b0, a_r_s} + {1'b0, i_osd_r};
        sum_g_s   = {1'b0, a_g_s} + {1'b0, i_osd_g};
        sum_b_s   = {1'b0, a_b_s} + {1'b0, i_osd_b};
        mix_r_s   = a_r_s;
        mix_g_s   = a_g_s;
        mix_b_s   = a_b_s;
        if (a_hit_s && !a_blank_s) begin
            case (a_mode_s)
                2'd1: begin
                    mix_r_s = i_osd_r;
                    mix_g_s = i_osd_g;
                    mix_b_s = i_osd_b;
                end
                2'd2: begin
                    if ({i_osd_r, i_osd_g, i_osd_b} != i_key) begin
                        mix_r_s = i_osd_r;
                        mix_g_s = i_osd_g;
                        mix_b_s = i_osd_b;
                    end else begin
                        mix_r_s = a_r_s;
                        mix_g_s = a_g_s;
                        mix_b_s = a_b_s;
                    end
                end
                2'd3: begin
                    mix_r_s = sum_r_s[C_bits:1];
                    mix_g_s = sum_g_s[C_bits:1];
                    mix_b_s = sum_b_s[C_bits:1];
                end
                default: begin
                    mix_r_s = a_r_s;
                    mix_g_s = a_g_s;
                    mix_b_s = a_b_s;
                end
            endcase
        end else begin
            mix_r_s = a_r_s;
            mix_g_s = a_g_s;
            mix_b_s = a_b_s;
        end
    end

    // Registered mixed video and delayed timing
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_blank <= 1'b0;
        end else if (clk_pixel_ena) begin
            o_r     <= mix_r_s;
            o_g     <= mix_g_s;
            o_b     <= mix_b_s;
            o_hsync <= a_hsync_s;
            o_vsync <= a_vsync_s;
            o_blank <= a_blank_s;
        end
    end

endmodule

// File: tb/tb_osd_mixer.sv
// tb_osd_mixer: randomized frames on a small raster against a pixel-level reference model.
// Two instances (C_latency 1 and 4) share the input stream; each has its own OSD source.
module tb_osd_mixer;

    localparam int H_ACT = 24, H_TOT = 32, V_FIRST = 3, V_ACT = 12, V_TOT = 16;

    logic        clk_pixel = 1'b0;
    logic        reset, clk_pixel_ena;
    logic [7:0]  i_r, i_g, i_b;
    logic        i_hsync, i_vsync, i_blank;
    logic [10:0] i_x0, i_y0, i_w, i_h;
    logic [1:0]  i_mode;
    logic [23:0] i_key;

    logic [10:0] o1_osd_x, o1_osd_y, o4_osd_x, o4_osd_y;
    logic        o1_osd_valid, o4_osd_valid;
    logic [7:0]  o1_r, o1_g, o1_b, o4_r, o4_g, o4_b;
    logic        o1_hs, o1_vs, o1_bl, o4_hs, o4_vs, o4_bl;

    logic [23:0] src1 [1] = '{default: 24'h000000};
    logic [23:0] src4 [4] = '{default: 24'h000000};

    int checks = 0, failures = 0;
    int pat = 0, chg_line = -1, chg_x0 = 0, rst_line = -1, rst_col = 0, ena_style = 0;
    int vid_const_en = 0, blend_chk = 0;
    logic [23:0] vid_const = 24'h000000;
    int cur_x = 0, cur_y = 0;

    // reference model state
    int sx0 = 0, sy0 = 0, sw = 0, sh = 0, smode = 0, prev_vs = 0;
    int m_valid = 0, m_ox = 0, m_oy = 0;
    logic [27:0] q1[$], q4[$];
    logic [27:0] last1 = '0, last4 = '0;

    always #5 clk_pixel = ~clk_pixel;

    osd_mixer #(.C_bits(8), .C_xy_bits(11), .C_latency(1)) dut1 (
        .clk_pixel(clk_pixel), .reset(reset), .clk_pixel_ena(clk_pixel_ena),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank),
        .i_x0(i_x0), .i_y0(i_y0), .i_w(i_w), .i_h(i_h), .i_mode(i_mode), .i_key(i_key),
        .i_osd_r(src1[0][23:16]), .i_osd_g(src1[0][15:8]), .i_osd_b(src1[0][7:0]),
        .o_osd_x(o1_osd_x), .o_osd_y(o1_osd_y), .o_osd_valid(o1_osd_valid),
        .o_r(o1_r), .o_g(o1_g), .o_b(o1_b), .o_hsync(o1_hs), .o_vsync(o1_vs), .o_blank(o1_bl));

    osd_mixer #(.C_bits(8), .C_xy_bits(11), .C_latency(4)) dut4 (
        .clk_pixel(clk_pixel), .reset(reset), .clk_pixel_ena(clk_pixel_ena),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank),
        .i_x0(i_x0), .i_y0(i_y0), .i_w(i_w), .i_h(i_h), .i_mode(i_mode), .i_key(i_key),
        .i_osd_r(src4[3][23:16]), .i_osd_g(src4[3][15:8]), .i_osd_b(src4[3][7:0]),
        .o_osd_x(o4_osd_x), .o_osd_y(o4_osd_y), .o_osd_valid(o4_osd_valid),
        .o_r(o4_r), .o_g(o4_g), .o_b(o4_b), .o_hsync(o4_hs), .o_vsync(o4_vs), .o_blank(o4_bl));

    // OSD image content as a function of window-relative coordinates
    function automatic logic [23:0] osd_pix(input int ox, input int oy, input int p, input logic [23:0] key);
        int a, b, c;
        logic [23:0] hv;
        a  = ox * 37 + oy * 11 + 5;
        b  = ((ox * 13) ^ (oy * 7)) + 3;
        c  = ox + oy * 29;
        hv = {a[7:0], b[7:0], c[7:0]};
        case (p)
            0:       return 24'hFF0000;
            1:       return (ox % 2 == 1) ? 24'h00FF00 : 24'h000000;
            2:       return 24'hFF00FF;
            3:       return hv;
            default: return ((ox + oy) % 3 == 0) ? key : hv;
        endcase
    endfunction

    // Expected pixel inside the window for a given mode
    function automatic logic [23:0] mix(input logic [23:0] v, input logic [23:0] o, input logic [23:0] key, input int mode);
        int r, g, b;
        r = (int'(v[23:16]) + int'(o[23:16])) / 2;
        g = (int'(v[15:8]) + int'(o[15:8])) / 2;
        b = (int'(v[7:0]) + int'(o[7:0])) / 2;
        case (mode)
            1:       return o;
            2:       return (o == key) ? v : o;
            3:       return {r[7:0], g[7:0], b[7:0]};
            default: return v;
        endcase
    endfunction

    // External OSD sources: C_latency enabled cycles from fetch coordinates to pixel
    always @(posedge clk_pixel) begin
        if (clk_pixel_ena) begin
            src1[0] <= osd_pix(int'(o1_osd_x), int'(o1_osd_y), pat, i_key);
            src4[0] <= osd_pix(int'(o4_osd_x), int'(o4_osd_y), pat, i_key);
            for (int i = 1; i < 4; i++) src4[i] <= src4[i-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit en, input bit rst);
        logic [23:0] v, o, mx;
        bit hit;
        reset = rst;
        clk_pixel_ena = en;
        if (!en) {i_r, i_g, i_b} = 24'($urandom);
        if (en && !rst) begin
            v   = {i_r, i_g, i_b};
            hit = !i_blank && cur_x >= sx0 && cur_x < sx0 + sw && cur_y >= sy0 && cur_y < sy0 + sh;
            o   = osd_pix(cur_x - sx0, cur_y - sy0, pat, i_key);
            mx  = hit ? mix(v, o, i_key, smode) : v;
            q1.push_back({hit && smode == 3, mx, i_hsync, i_vsync, i_blank});
            q4.push_back({hit && smode == 3, mx, i_hsync, i_vsync, i_blank});
            m_valid = hit;
            if (hit) begin
                m_ox = cur_x - sx0;
                m_oy = cur_y - sy0;
            end
            if (i_vsync && prev_vs == 0) begin
                sx0 = int'(i_x0); sy0 = int'(i_y0); sw = int'(i_w); sh = int'(i_h); smode = int'(i_mode);
            end
            prev_vs = i_vsync;
        end
        @(posedge clk_pixel);
        #1;
        if (rst) begin
            q1.delete(); q4.delete();
            repeat (2) q1.push_back('0);
            repeat (5) q4.push_back('0);
            last1 = '0; last4 = '0;
            sx0 = 0; sy0 = 0; sw = 0; sh = 0; smode = 0; prev_vs = 0;
            m_valid = 0; m_ox = 0; m_oy = 0;
        end else if (en) begin
            last1 = q1.pop_front();
            last4 = q4.pop_front();
        end
        check("video1", {5'd0, o1_r, o1_g, o1_b, o1_hs, o1_vs, o1_bl}, {5'd0, last1[26:0]});
        check("video4", {5'd0, o4_r, o4_g, o4_b, o4_hs, o4_vs, o4_bl}, {5'd0, last4[26:0]});
        check("osd_valid1", {31'd0, o1_osd_valid}, m_valid);
        check("osd_x1", {21'd0, o1_osd_x}, m_ox);
        check("osd_y1", {21'd0, o1_osd_y}, m_oy);
        check("osd_valid4", {31'd0, o4_osd_valid}, m_valid);
        check("osd_x4", {21'd0, o4_osd_x}, m_ox);
        if (blend_chk != 0 && last1[27]) check("blend1", {8'd0, o1_r, o1_g, o1_b}, 32'h00BF208F);
        if (blend_chk != 0 && last4[27]) check("blend4", {8'd0, o4_r, o4_g, o4_b}, 32'h00BF208F);
    endtask

    task automatic set_win(input int x0, input int y0, input int w, input int h, input int m);
        i_x0 = x0[10:0]; i_y0 = y0[10:0]; i_w = w[10:0]; i_h = h[10:0]; i_mode = m[1:0];
    endtask

    task automatic run_frame();
        logic [23:0] v;
        for (int l = 0; l < V_TOT; l++) begin
            for (int c = 0; c < H_TOT; c++) begin
                if (l == chg_line && c == 0) i_x0 = chg_x0[10:0];
                if (l == rst_line && c == rst_col) step(1'b0, 1'b1);
                i_vsync = (l < 2);
                i_blank = !(l >= V_FIRST && l < V_FIRST + V_ACT && c < H_ACT);
                i_hsync = (c >= 26 && c < 29);
                cur_x = c;
                cur_y = l - V_FIRST;
                case (ena_style)
                    1: step(1'b0, 1'b0);
                    2: if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0);
                    default: ;
                endcase
                v = (vid_const_en != 0) ? vid_const : 24'($urandom);
                {i_r, i_g, i_b} = v;
                step(1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        {i_r, i_g, i_b} = 24'h000000;
        i_hsync = 1'b0; i_vsync = 1'b0; i_blank = 1'b1;
        i_key = 24'h000000;
        set_win(5, 2, 8, 4, 1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        // opaque red window
        pat = 0; run_frame();
        // colour key: OSD alternates key colour / green
        set_win(3, 1, 10, 5, 2); i_key = 24'h000000; pat = 1; run_frame();
        // blend with constant video
        set_win(4, 3, 9, 6, 3); pat = 2; vid_const_en = 1; vid_const = 24'h804020; blend_chk = 1;
        run_frame();
        vid_const_en = 0; blend_chk = 0;
        // mid-frame origin change is ignored until the next frame
        set_win(5, 2, 8, 4, 1); pat = 3; chg_line = 6; chg_x0 = 15; run_frame();
        chg_line = -1;
        ena_style = 1; run_frame();
        // clipped window at the line end, colour key with matching pixels
        ena_style = 0; set_win(18, 0, 20, 12, 2); pat = 4; i_key = 24'h3C5A7E; run_frame();
        // zero width, then zero height
        set_win(0, 0, 0, 12, 1); pat = 0; run_frame();
        ena_style = 2; set_win(0, 0, 24, 0, 1); run_frame();

        // random frames, one with a reset mid-line
        for (int f = 0; f < 5; f++) begin
            set_win($urandom_range(0, 25), $urandom_range(0, 13), $urandom_range(0, 26),
                    $urandom_range(0, 13), $urandom_range(0, 3));
            pat   = $urandom_range(0, 4);
            i_key = (pat == 4) ? 24'($urandom) : 24'h000000;
            rst_line = (f == 1) ? 7 : -1;
            rst_col  = 10;
            run_frame();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
